// File: rtl/comb_decim_fxp_if.sv
// comb_decim_fxp_if: sample stream into and out of the decimating comb section
interface comb_decim_fxp_if #(parameter int width = 16);
  logic in_valid;
  logic signed [width-1:0] in_data;
  logic out_valid;
  logic signed [width-1:0] out_data;
  logic out_settled;
  modport master(output in_valid, in_data, input out_valid, out_data, out_settled);
  modport slave(input in_valid, in_data, output out_valid, out_data, out_settled);
endinterface

// File: rtl/comb_decim_fxp.sv
// comb_decim_fxp: keeps every rate-th valid sample and runs it through a cascade of registered differencers
module comb_decim_fxp #(
  parameter int width = 16,
  parameter int stages = 3,
  parameter int rate = 8,
  parameter int diff_delay = 1
) (
  input logic clk,
  input logic rst,
  comb_decim_fxp_if.slave bus
);
  localparam int cw = $clog2(rate);
  localparam int settle = stages * diff_delay;
  localparam int ow = $clog2(settle + 1);
  logic [cw-1:0] cnt;
  logic [ow-1:0] ocnt;
  logic settled;
  logic keep;
  logic [stages:0] v;
  logic [width-1:0] x_d [stages+1];
  logic [width-1:0] dl [stages][diff_delay];
  assign keep = bus.in_valid && cnt == cw'(rate - 1);
  // v[0]/x_d[0] is the capture stage; v[k]/x_d[k] is the output of comb k
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      ocnt <= '0;
      settled <= 1'b0;
      v <= '0;
      x_d <= '{default: '0};
      dl <= '{default: '{default: '0}};
    end else begin
      if (bus.in_valid) cnt <= (cnt == cw'(rate - 1)) ? '0 : cnt + 1'b1;
      v <= {v[stages-1:0], keep};
      if (keep) x_d[0] <= bus.in_data;
      for (int k = 0; k < stages; k++)
        if (v[k]) begin
          x_d[k+1] <= x_d[k] - dl[k][diff_delay-1];
          dl[k][0] <= x_d[k];
          for (int i = 1; i < diff_delay; i++) dl[k][i] <= dl[k][i-1];
        end
      if (v[stages-1]) begin
        if (ocnt == ow'(settle)) settled <= 1'b1;
        else ocnt <= ocnt + 1'b1;
      end
    end
  assign bus.out_valid = v[stages];
  assign bus.out_data = x_d[stages];
  assign bus.out_settled = settled;
endmodule

// File: tb/tb_comb_decim_fxp.sv
// tb_comb_decim_fxp: five parameterisations fed one random/directed stream, checked against a sequence-level model
module tb_comb_decim_fxp;
  localparam int ni = 5;
  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [15:0] in_data;
  logic ov [ni];
  logic [15:0] od [ni];
  logic os [ni];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vcnt [ni];
  int ocnt [ni];
  logic [15:0] hold [ni];
  logic [15:0] kq [ni][$];
  int due_q [ni][$];
  logic [15:0] exp_q [ni][$];
  logic [15:0] obs [ni][$];
  always #5 clk = ~clk;
  function automatic int st(int i); return (i == 1 || i == 4) ? 3 : 1; endfunction
  function automatic int rt(int i); return i == 4 ? 8 : (i >= 2 ? 2 : 4); endfunction
  function automatic int dd(int i); return i == 3 ? 2 : 1; endfunction
  for (genvar g = 0; g < ni; g++) begin : g_dut
    comb_decim_fxp_if #(.width(16)) bus ();
    comb_decim_fxp #(
      .width(16),
      .stages((g == 1 || g == 4) ? 3 : 1),
      .rate(g == 4 ? 8 : (g >= 2 ? 2 : 4)),
      .diff_delay(g == 3 ? 2 : 1)
    ) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    assign bus.in_valid = in_valid;
    assign bus.in_data = in_data;
    assign ov[g] = bus.out_valid;
    assign od[g] = bus.out_data;
    assign os[g] = bus.out_settled;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h cycle=%0d", tag, got, want, cyc);
    end
  endtask
  // last element of the kept sequence after `s` cascaded y[n]=x[n]-x[n-m] passes with zero history
  function automatic logic [15:0] comb_y(input logic [15:0] q[$], input int s, input int m);
    logic [15:0] a [$];
    a = q;
    for (int p = 0; p < s; p++)
      for (int j = a.size() - 1; j >= m; j--) a[j] = a[j] - a[j-m];
    return a[a.size()-1];
  endfunction
  task automatic step(input logic r, input logic v, input logic [15:0] d);
    logic ev;
    rst = r;
    in_valid = v;
    in_data = d;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < ni; i++)
      if (r) begin
        kq[i].delete();
        due_q[i].delete();
        exp_q[i].delete();
        obs[i].delete();
        vcnt[i] = 0;
        ocnt[i] = 0;
        hold[i] = '0;
      end else if (v) begin
        vcnt[i]++;
        if (vcnt[i] % rt(i) == 0) begin
          kq[i].push_back(d);
          due_q[i].push_back(cyc + st(i));
          exp_q[i].push_back(comb_y(kq[i], st(i), dd(i)));
        end
      end
    #1;
    for (int i = 0; i < ni; i++) begin
      ev = due_q[i].size() != 0 && due_q[i][0] == cyc;
      if (ev) begin
        void'(due_q[i].pop_front());
        hold[i] = exp_q[i].pop_front();
        ocnt[i]++;
      end
      if (ov[i]) obs[i].push_back(od[i]);
      chk($sformatf("out_valid[%0d]", i), 32'(ov[i]), 32'(ev));
      chk($sformatf("out_data[%0d]", i), 32'(od[i]), 32'(hold[i]));
      chk($sformatf("out_settled[%0d]", i), 32'(os[i]), 32'(ocnt[i] > st(i) * dd(i)));
    end
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 16'h0);
  endtask
  initial begin
    logic [15:0] p1 [4] = '{16'd3, 16'd4, 16'd4, 16'd4};
    logic [15:0] p2 [5] = '{16'd5, 16'hFFF6, 16'd5, 16'd0, 16'd0};
    logic [15:0] p3 [2] = '{16'h7FFF, 16'h0001};
    logic [15:0] p6i [5] = '{16'd1, 16'd2, 16'd4, 16'd8, 16'd16};
    logic [15:0] p6o [5] = '{16'd1, 16'd2, 16'd3, 16'd6, 16'd12};
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    repeat (2) step(1'b1, 1'b0, 16'h0);
    for (int n = 0; n < 20; n++) step(1'b0, 1'b1, 16'(n));
    idle(4);
    chk("ramp_count", obs[0].size(), 5);
    for (int k = 0; k < 4; k++) chk($sformatf("ramp_out%0d", k), obs[0][k], p1[k]);
    step(1'b1, 1'b0, 16'h0);
    repeat (24) step(1'b0, 1'b1, 16'd5);
    for (int k = 0; k < 5; k++) chk($sformatf("const_out%0d", k), obs[1][k], p2[k]);
    step(1'b1, 1'b0, 16'h0);
    step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b1, 16'h7FFF);
    step(1'b0, 1'b1, 16'h0);
    step(1'b0, 1'b1, 16'h8000);
    idle(4);
    for (int k = 0; k < 2; k++) chk($sformatf("wrap_out%0d", k), obs[2][k], p3[k]);
    step(1'b1, 1'b0, 16'h0);
    for (int n = 0; n < 32; n++) step(1'b0, n % 2 == 0, 16'($urandom));
    idle(8);
    chk("toggle_count", obs[0].size(), 4);
    step(1'b1, 1'b0, 16'h0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b1, 16'h0);
      step(1'b0, 1'b1, p6i[k]);
    end
    idle(4);
    for (int k = 0; k < 5; k++) chk($sformatf("m2_out%0d", k), obs[3][k], p6o[k]);
    step(1'b1, 1'b0, 16'h0);
    repeat (6) step(1'b0, 1'b1, 16'($urandom));
    step(1'b1, 1'b0, 16'h0);
    repeat (3) step(1'b0, 1'b1, 16'($urandom));
    idle(6);
    chk("rst_none", obs[1].size(), 0);
    step(1'b0, 1'b1, 16'h1234);
    idle(6);
    chk("rst_first", obs[1][0], 16'h1234);
    step(1'b1, 1'b0, 16'h0);
    repeat (3000) step($urandom_range(299) == 0, $urandom_range(9) < 7, 16'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/comb_decim_fxp.md
Name: comb_decim_fxp

Overview:
- Decimating comb (differencer) section of a CIC decimator.
- Takes a signed fixed-point stream from the integrator chain, which is built from pipelined fixed-point adders, and keeps every RATE-th valid sample.
- Runs the kept samples through STAGES registered differencers, y[n] = x[n] - x[n-DIFF_DELAY], so it undoes the integration on the read side.
- Sits between the integrator chain and the synchroniser's correlator. Output is a valid-qualified, decimated signed stream.

Parameters:
- width, 16, data width of input, internal registers and output; two's complement.
- stages, 3, number of cascaded comb stages (1..8).
- rate, 8, decimation factor (2..256).
- diff_delay, 1, differential delay M of each comb, in decimated samples (1 or 2).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies in_data for one cycle; may be high any number of consecutive cycles or have gaps.
- in_data  input  width  signed integrator output.
- out_valid  output  1  single-cycle strobe marking a new out_data.
- out_data  output  width  signed comb output; held between strobes.
- out_settled  output  1  high once the start-up transient has flushed.

Behaviour:
- Reset (rst high at a posedge): decimation counter=0, all comb delay lines=0, pipeline valids=0, out_valid=0, out_data=0, out_settled=0. rst has priority over in_valid in the same cycle.
- Decimation counter: 0..rate-1, advances only on in_valid, wraps to 0.
  - A sample is kept when in_valid=1 and counter==rate-1. The first kept sample after reset is the rate-th valid input.
  - Non-kept valid samples are discarded. Cycles with in_valid=0 change nothing.
- Kept sample is registered in the capture stage (1 cycle).
- Stage k (k=1..stages) is registered and advances only when its input valid is high:
  - y_k = x_k - d_k[diff_delay-1], where d_k is a shift line of the last diff_delay accepted x_k values.
  - d_k shifts only on a valid x_k.
- Latency: a sample kept at posedge T produces out_valid=1 at posedge T+1+stages. Pipeline valids are a shift chain, so kept samples one cycle apart are fully pipelined, one output per kept input.
- Arithmetic: all differences are modulo 2^width, with wrap-around and no saturation. CIC output is exact despite intermediate wrap, provided width >= input bits + stages*log2(rate*diff_delay) upstream.
- out_data updates only on out_valid cycles; otherwise it holds its previous value.
- out_settled: an output counter saturates at stages*diff_delay. out_settled rises together with the (stages*diff_delay+1)-th out_valid and stays high until reset.
- Reset mid-operation: in-flight samples are dropped, no out_valid follows reset, and the counter restarts so the next kept sample is again the rate-th valid input after reset.
- No backpressure: the consumer must accept every out_valid strobe.

Test Plan:
- Defaults except stages=1, rate=4; in_valid continuous, in_data = n (n=0,1,2,...) -> kept 3,7,11,15 -> out_data 3,4,4,4. First out_valid 2 cycles after the cycle in_data=3 is sampled. out_settled rises with the 2nd output.
- stages=3, rate=4, diff_delay=1, in_data constant 5 every cycle -> outputs 5, -10, 5, 0, 0...; out_settled high from the 4th output; latency 4 cycles from each kept sample.
- Wrap: stages=1, rate=2, width=16, inputs giving kept samples 0x7FFF then 0x8000 -> out_data 0x7FFF then 0x0001.
- in_valid toggling 1-0-1-0 with rate=4 -> exactly one out_valid per 4 valid inputs, i.e. per 8 cycles; the counter does not advance on idle cycles; out_data held between strobes.
- Assert rst for 1 cycle while 2 samples are in flight (stages=3) -> no out_valid afterwards until 4 new valid inputs; out_data=0, out_settled=0 after reset; first post-reset output equals the kept input value (delay lines cleared).
- diff_delay=2, stages=1, rate=2, kept sequence 1,2,4,8,16 -> outputs 1,2,3,6,12.
